alu_seq_7seg: RTL and testbench

- Clocked, parametrised successor to the 2-bit add/multiply-to-7-segment datapath.
- Operands are W bits wide. The operation is selected by a 2-bit opcode and launched with a start/busy/done handshake.
- Multiplication is a multi-cycle shift-add. The 2W-bit result is held in a register and shown on a time-multiplexed multi-digit hex display.
- Sits between board switches/buttons and the 7-segment display, replacing the purely combinational path.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/hex7seg_dec.sv | 11 +
 rtl/alu_seq_7seg.sv | 141 ++++++++++++++
 tb/tb_alu_seq_7seg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU with multiplexed hex display:
// opcodes, controller states and the seven-segment glyph table.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; entry 0 sits in the rightmost slot.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex digit to seven-segment decoder (active-high segments).
module hex7seg_dec
  import alu_seq_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/alu_seq_7seg.sv
// Start/busy/done ALU with shift-add multiplier; the 2W-bit result is shown
// on a time-multiplexed hex display that scans independently of the ALU.
module alu_seq_7seg
  import alu_seq_pkg::*;
#(
  parameter  int W        = 4,
  parameter  int SCAN_DIV = 50000,
  localparam int NDIG     = (2 * W + 3) / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  input  logic [1:0]        op,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2*W-1:0]    result,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an
);

  localparam int RW   = 2 * W;
  localparam int PADW = 4 * NDIG;
  localparam int CW   = $clog2(W + 1);
  localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          r_state;
  state_t          w_stateNext;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic [RW-1:0]   r_result;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_mcand;
  logic [W-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [RW-1:0]   w_aluRes;
  logic [RW-1:0]   w_accNext;
  logic [SCW-1:0]  r_scanCnt;
  logic [IDXW-1:0] r_digIdx;
  logic [PADW-1:0] w_padded;
  logic [3:0]      w_nibble;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (start) w_stateNext = CALC;
      CALC: w_stateNext = (r_op == OP_MUL) ? MUL : DONE;
      MUL:  if (r_cnt == CW'(1)) w_stateNext = DONE;
      DONE: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    w_aluRes = RW'(r_a);
    case (r_op)
      OP_ADD:  w_aluRes = RW'(r_a) + RW'(r_b);
      OP_SUB:  w_aluRes = RW'(r_a) - RW'(r_b);
      default: w_aluRes = RW'(r_a);
    endcase
  end

  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The final MUL step commits the accumulator including that step's addend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a  <= a;
            r_b  <= b;
            r_op <= op;
          end
        end
        CALC: begin
          if (r_op == OP_MUL) begin
            r_acc    <= '0;
            r_mcand  <= RW'(r_a);
            r_mplier <= r_b;
            r_cnt    <= CW'(W);
          end else begin
            r_result <= w_aluRes;
          end
        end
        MUL: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_result <= w_accNext;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scanCnt <= '0;
      r_digIdx  <= '0;
    end else if (r_scanCnt == SCW'(SCAN_DIV - 1)) begin
      r_scanCnt <= '0;
      r_digIdx  <= (r_digIdx == IDXW'(NDIG - 1)) ? '0 : r_digIdx + IDXW'(1);
    end else begin
      r_scanCnt <= r_scanCnt + SCW'(1);
    end
  end

  // Upper nibble reads as zero when 2W is not a multiple of four.
  assign w_padded = PADW'(r_result);
  assign w_nibble = w_padded[{r_digIdx, 2'b00} +: 4];
  assign an       = NDIG'(1) << r_digIdx;

  hex7seg_dec u_dec (
    .i_nibble(w_nibble),
    .o_seg   (seg)
  );

endmodule

// File: tb/tb_alu_seq_7seg.sv
// Directed bench for alu_seq_7seg (W=4, SCAN_DIV=4) with a queue-based
// scoreboard checked by a monitor on every done pulse.
module tb_alu_seq_7seg;

  localparam int W        = 4;
  localparam int SCAN_DIV = 4;
  localparam int NDIG     = 2;

  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_E = 7'b1111001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [1:0]      op;
  logic            start;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  result;
  logic [6:0]      seg;
  logic [NDIG-1:0] an;

  int checks = 0;
  int errors = 0;
  int cycCnt = 0;

  typedef struct {
    logic [7:0] res;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sbQ[$];

  alu_seq_7seg #(.W(W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .result(result),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected done", 32'(done), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput({e.name, " result"}, 32'(result), 32'(e.res));
        checkOutput({e.name, " done cycle"}, cycCnt, e.cyc);
      end
    end
  end

  // lat = number of cycles busy stays high; done lands in the last of them.
  task automatic applyStimulus(input string name, input logic [3:0] ia,
                               input logic [3:0] ib, input logic [1:0] iop,
                               input logic [7:0] expRes, input int lat,
                               input int pokeAt);
    exp_t e;
    int   busyCnt;
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    e.res = expRes; e.cyc = cycCnt + lat; e.name = name;
    sbQ.push_back(e);
    busyCnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0; a = ~ia; b = ~ib; op = ~iop;
      if (i == pokeAt) begin
        start = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
      end
      if (busy) busyCnt++;
      #1;
      if (sbQ.size() == 0) break;
    end
    checkOutput({name, " completes"}, sbQ.size(), 0);
    sbQ.delete();
    checkOutput({name, " busy cycles"}, busyCnt, lat);
    @(negedge clk);
    checkOutput({name, " busy after"}, 32'(busy), 32'd0);
    checkOutput({name, " done single"}, 32'(done), 32'd0);
    checkOutput({name, " result held"}, 32'(result), 32'(expRes));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NDIG-1:0] prevAn;
    int run, trans, doneSeen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; op = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'(result), 32'h00);
    checkOutput("reset an", 32'(an), 32'b01);
    checkOutput("reset seg", 32'(seg), 32'b0111111);
    rst_n = 1'b1;

    applyStimulus("add 9+7",  4'd9,  4'd7,  2'b00, 8'h10, 2, 0);
    applyStimulus("sub 3-5",  4'd3,  4'd5,  2'b01, 8'hFE, 2, 0);
    applyStimulus("pass C",   4'hC,  4'd0,  2'b11, 8'h0C, 2, 0);
    applyStimulus("add F+F",  4'hF,  4'hF,  2'b00, 8'h1E, 2, 0);
    applyStimulus("mul F*F",  4'hF,  4'hF,  2'b10, 8'hE1, W + 2, 0);
    applyStimulus("mul 0*9",  4'd0,  4'd9,  2'b10, 8'h00, W + 2, 0);
    applyStimulus("mul D*B",  4'hD,  4'hB,  2'b10, 8'h8F, W + 2, 0);
    applyStimulus("mul C*A poked", 4'hC, 4'hA, 2'b10, 8'h78, W + 2, 3);
    applyStimulus("mul F*F again", 4'hF, 4'hF, 2'b10, 8'hE1, W + 2, 0);

    prevAn = an; run = 0; trans = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      checkOutput("scan an one-hot", 32'(an == 2'b01 || an == 2'b10), 32'd1);
      checkOutput("scan seg", 32'(seg), 32'((an == 2'b10) ? SEG_E : SEG_1));
      if (an == prevAn) begin
        run++;
      end else begin
        if (trans > 0) checkOutput("scan dwell", run, SCAN_DIV);
        trans++;
        run = 1;
        prevAn = an;
      end
    end
    checkOutput("scan transitions", 32'(trans >= 4), 32'd1);

    @(negedge clk);
    a = 4'hF; b = 4'hF; op = 2'b10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mid-mul busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort result", 32'(result), 32'h00);
    checkOutput("abort busy", 32'(busy), 32'd0);
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort no done", doneSeen, 0);
    checkOutput("abort idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
